// File: rtl/pwl_transform_pipe.sv
// pwl_transform_pipe: 5-stage streaming piecewise-linear curve out = C[k] + (x - M[k]) * D[k],
// with a double-buffered segment table swapped at frame boundaries. Define PWL_BYPASS_EN for a bypass input.
module pwl_transform_pipe #(
  parameter int DSIZE = 12,
  parameter int DT_I  = 8,
  parameter int DT_D  = 4,
  parameter int SEGS  = 16,
  parameter int AW    = 4,
  parameter int WW    = 12
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [DSIZE-1:0] in_data,
`ifdef PWL_BYPASS_EN
  input  logic             bypass,
`endif
  output logic             out_valid,
  output logic             out_sof,
  output logic [DSIZE-1:0] out_data,
  output logic             out_sat,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [AW-1:0]    cfg_idx,
  input  logic [WW-1:0]    cfg_wdata,
  input  logic             swap_req,
  output logic             swap_pend,
  output logic             swap_done
);

  localparam int DW = DT_I + DT_D;
  localparam int PW = DSIZE + DW;
  localparam int RW = PW - DT_D + 1;
  localparam int SW = RW + 1;
  localparam int CW = AW + 1;

  function automatic logic [CW-1:0] count_ones(input logic [SEGS-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < SEGS; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  function automatic logic [RW-1:0] round_half_up(input logic [PW-1:0] p);
    logic [PW:0] t;
    t = {1'b0, p} + ((PW+1)'(1) << (DT_D - 1));
    return RW'(t >> DT_D);
  endfunction

  function automatic logic [DSIZE:0] saturate(input logic [SW-1:0] s);
    if (|s[SW-1:DSIZE]) return {1'b1, {DSIZE{1'b1}}};
    return {1'b0, s[DSIZE-1:0]};
  endfunction

  logic byp_in;
`ifdef PWL_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  logic [DSIZE-1:0] act_m_q [SEGS];
  logic [DSIZE-1:0] act_m_d [SEGS];
  logic [DSIZE-1:0] act_c_q [SEGS];
  logic [DSIZE-1:0] act_c_d [SEGS];
  logic [DW-1:0]    act_d_q [SEGS];
  logic [DW-1:0]    act_d_d [SEGS];
  logic [DSIZE-1:0] sh_m_q  [SEGS];
  logic [DSIZE-1:0] sh_m_d  [SEGS];
  logic [DSIZE-1:0] sh_c_q  [SEGS];
  logic [DSIZE-1:0] sh_c_d  [SEGS];
  logic [DW-1:0]    sh_d_q  [SEGS];
  logic [DW-1:0]    sh_d_d  [SEGS];

  logic swap_pend_q, swap_pend_d, swap_done_q, swap_done_d;
  logic pipe_busy, swap_now;

  logic             vld_p1_q, vld_p1_d, sof_p1_q, sof_p1_d, byp_p1_q, byp_p1_d;
  logic [DSIZE-1:0] x_p1_q, x_p1_d;
  logic [SEGS-1:0]  cmp_p1_q, cmp_p1_d;

  logic [CW-1:0]    cnt;
  logic [AW-1:0]    k;
  logic             vld_p2_q, vld_p2_d, sof_p2_q, sof_p2_d, byp_p2_q, byp_p2_d;
  logic [DSIZE-1:0] x_p2_q, x_p2_d, m_p2_q, m_p2_d, c_p2_q, c_p2_d;
  logic [DW-1:0]    d_p2_q, d_p2_d;

  logic             vld_p3_q, vld_p3_d, sof_p3_q, sof_p3_d, byp_p3_q, byp_p3_d;
  logic [DSIZE-1:0] x_p3_q, x_p3_d, c_p3_q, c_p3_d, sub_p3_q, sub_p3_d;
  logic [DW-1:0]    d_p3_q, d_p3_d;

  logic             vld_p4_q, vld_p4_d, sof_p4_q, sof_p4_d, byp_p4_q, byp_p4_d;
  logic [DSIZE-1:0] x_p4_q, x_p4_d, c_p4_q, c_p4_d;
  logic [PW-1:0]    prod_p4_q, prod_p4_d;

  logic [RW-1:0]    rnd;
  logic [SW-1:0]    sum;
  logic [DSIZE:0]   res;
  logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_sat_q, out_sat_d;
  logic [DSIZE-1:0] out_data_q, out_data_d;

  always_comb begin
    // Swap fires on an accepted SOF or when the whole pipe is idle; the copy takes the pre-write shadow.
    pipe_busy   = vld_p1_q | vld_p2_q | vld_p3_q | vld_p4_q | out_valid_q;
    swap_now    = swap_pend_q & (in_valid ? in_sof : ~pipe_busy);
    swap_pend_d = swap_now ? swap_req : (swap_pend_q | swap_req);
    swap_done_d = swap_now;
    act_m_d = swap_now ? sh_m_q : act_m_q;
    act_c_d = swap_now ? sh_c_q : act_c_q;
    act_d_d = swap_now ? sh_d_q : act_d_q;
    sh_m_d  = sh_m_q;
    sh_c_d  = sh_c_q;
    sh_d_d  = sh_d_q;
    if (cfg_we) begin
      case (cfg_sel)
        2'b00:   sh_m_d[cfg_idx] = cfg_wdata[DSIZE-1:0];
        2'b01:   sh_c_d[cfg_idx] = cfg_wdata[DSIZE-1:0];
        2'b10:   sh_d_d[cfg_idx] = cfg_wdata[DW-1:0];
        default: ;
      endcase
    end

    // S1: breakpoint compare; an SOF sample taking the swap compares against the incoming bank.
    vld_p1_d = in_valid;
    sof_p1_d = in_sof;
    byp_p1_d = byp_in;
    x_p1_d   = in_data;
    for (int i = 0; i < SEGS; i++)
      cmp_p1_d[i] = in_data > (swap_now ? sh_m_q[i] : act_m_q[i]);

    // S2: segment select and coefficient latch; each sample carries its own M/C/D from here on.
    cnt      = count_ones(cmp_p1_q);
    k        = (cnt == '0) ? '0 : AW'(cnt - CW'(1));
    vld_p2_d = vld_p1_q;
    sof_p2_d = sof_p1_q;
    byp_p2_d = byp_p1_q;
    x_p2_d   = x_p1_q;
    m_p2_d   = act_m_q[k];
    c_p2_d   = act_c_q[k];
    d_p2_d   = act_d_q[k];

    // S3: offset into segment
    vld_p3_d = vld_p2_q;
    sof_p3_d = sof_p2_q;
    byp_p3_d = byp_p2_q;
    x_p3_d   = x_p2_q;
    c_p3_d   = c_p2_q;
    d_p3_d   = d_p2_q;
    sub_p3_d = (x_p2_q > m_p2_q) ? (x_p2_q - m_p2_q) : '0;

    // S4: slope multiply
    vld_p4_d  = vld_p3_q;
    sof_p4_d  = sof_p3_q;
    byp_p4_d  = byp_p3_q;
    x_p4_d    = x_p3_q;
    c_p4_d    = c_p3_q;
    prod_p4_d = PW'(sub_p3_q) * PW'(d_p3_q);

    // S5: round, add offset, saturate; output holds through bubbles
    rnd = round_half_up(prod_p4_q);
    sum = SW'(c_p4_q) + SW'(rnd);
    res = saturate(sum);
    if (byp_p4_q) res = {1'b0, x_p4_q};
    out_valid_d = vld_p4_q;
    out_sof_d   = vld_p4_q & sof_p4_q;
    out_data_d  = vld_p4_q ? res[DSIZE-1:0] : out_data_q;
    out_sat_d   = vld_p4_q ? res[DSIZE] : out_sat_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      vld_p4_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_sat_q   <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < SEGS; i++) begin
        act_m_q[i] <= '0;
        act_c_q[i] <= '0;
        act_d_q[i] <= DW'(1) << DT_D;
        sh_m_q[i]  <= '0;
        sh_c_q[i]  <= '0;
        sh_d_q[i]  <= DW'(1) << DT_D;
      end
    end else begin
      swap_pend_q <= swap_pend_d;
      swap_done_q <= swap_done_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      vld_p3_q    <= vld_p3_d;
      vld_p4_q    <= vld_p4_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_sat_q   <= out_sat_d;
      out_data_q  <= out_data_d;
      act_m_q     <= act_m_d;
      act_c_q     <= act_c_d;
      act_d_q     <= act_d_d;
      sh_m_q      <= sh_m_d;
      sh_c_q      <= sh_c_d;
      sh_d_q      <= sh_d_d;
    end
  end

  always_ff @(posedge clock) begin
    sof_p1_q  <= sof_p1_d;
    byp_p1_q  <= byp_p1_d;
    x_p1_q    <= x_p1_d;
    cmp_p1_q  <= cmp_p1_d;
    sof_p2_q  <= sof_p2_d;
    byp_p2_q  <= byp_p2_d;
    x_p2_q    <= x_p2_d;
    m_p2_q    <= m_p2_d;
    c_p2_q    <= c_p2_d;
    d_p2_q    <= d_p2_d;
    sof_p3_q  <= sof_p3_d;
    byp_p3_q  <= byp_p3_d;
    x_p3_q    <= x_p3_d;
    c_p3_q    <= c_p3_d;
    d_p3_q    <= d_p3_d;
    sub_p3_q  <= sub_p3_d;
    sof_p4_q  <= sof_p4_d;
    byp_p4_q  <= byp_p4_d;
    x_p4_q    <= x_p4_d;
    c_p4_q    <= c_p4_d;
    prod_p4_q <= prod_p4_d;
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign swap_pend = swap_pend_q;
  assign swap_done = swap_done_q;

endmodule
